// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: Tuse/Tnew stall detection plus D/E/M forwarding selects for the 5-stage MIPS pipe.
// Latency: 0 cycles; every output is combinational on the D-stage inputs and the shadow E/M/W slots.
// Backpressure: a stall freezes PC and F/D and flushes D/E; it holds for as long as the hazard persists.
// Optional HAZARD_PERF_EN: adds a wrapping stall-cycle counter; without it stall_cnt is tied to 0.
module hazard_ctrl #(
  parameter int TNEW_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        D_A1,
  input  logic [4:0]        D_A2,
  input  logic              D_A1use,
  input  logic              D_A2use,
  input  logic [1:0]        D_Tuse_rs,
  input  logic [1:0]        D_Tuse_rt,
  input  logic [4:0]        D_A3,
  input  logic              D_Reg_Write,
  input  logic [TNEW_W-1:0] D_Tnew,
  output logic              F_PC_WE,
  output logic              F_D_RegWE,
  output logic              D_E_RegWE,
  output logic              D_E_clear,
  output logic [1:0]        Fwd_D_rs,
  output logic [1:0]        Fwd_D_rt,
  output logic [1:0]        Fwd_E_rs,
  output logic [1:0]        Fwd_E_rt,
  output logic              Fwd_M_rt,
  output logic [CNT_W-1:0]  stall_cnt
);

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic [4:0]        a1;
    logic [4:0]        a2;
    logic [4:0]        a3;
    logic              we;
    logic [TNEW_W-1:0] tnew;
  } slot_t;

  slot_t e_q, m_q, w_q;
  logic  stall;

  // Tnew counts down one per stage and parks at zero once the result exists.
  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] x);
    return (x != '0) ? (x - {{(TNEW_W-1){1'b0}}, 1'b1}) : '0;
  endfunction

  // A slot supplies register a only if it really writes it; $0 never matches.
  function automatic logic wr_hit(input slot_t s, input logic [4:0] a);
    return s.we && (s.a3 != 5'd0) && (s.a3 == a);
  endfunction

  // Shadow pipeline advance: bubble into E on stall, otherwise capture the D instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      if (stall) begin
        e_q <= '0;
      end else begin
        e_q.a1   <= D_A1;
        e_q.a2   <= D_A2;
        e_q.a3   <= D_A3;
        e_q.we   <= D_Reg_Write;
        e_q.tnew <= sat_dec(D_Tnew);
      end
      m_q      <= e_q;
      m_q.tnew <= sat_dec(e_q.tnew);
      w_q      <= m_q;
      w_q.tnew <= sat_dec(m_q.tnew);
    end
  end

  // Stall when an E/M producer cannot deliver before the D consumer needs the value.
  always_comb begin
    logic [TNEW_W-1:0] tuse_rs;
    logic [TNEW_W-1:0] tuse_rt;
    logic              stall_rs;
    logic              stall_rt;
    tuse_rs  = {{(TNEW_W-2){1'b0}}, D_Tuse_rs};
    tuse_rt  = {{(TNEW_W-2){1'b0}}, D_Tuse_rt};
    stall_rs = D_A1use && (D_A1 != 5'd0) &&
               ((wr_hit(e_q, D_A1) && (e_q.tnew > tuse_rs)) ||
                (wr_hit(m_q, D_A1) && (m_q.tnew > tuse_rs)));
    stall_rt = D_A2use && (D_A2 != 5'd0) &&
               ((wr_hit(e_q, D_A2) && (e_q.tnew > tuse_rt)) ||
                (wr_hit(m_q, D_A2) && (m_q.tnew > tuse_rt)));
    stall     = stall_rs || stall_rt;
    F_PC_WE   = !stall;
    F_D_RegWE = !stall;
    D_E_RegWE = 1'b1;
    D_E_clear = stall;
  end

  // Forwarding selects: youngest ready producer wins; W->D goes through the GRF bypass instead.
  always_comb begin
    Fwd_D_rs = 2'd0;
    Fwd_D_rt = 2'd0;
    Fwd_E_rs = 2'd0;
    Fwd_E_rt = 2'd0;
    Fwd_M_rt = 1'b0;

    if (wr_hit(e_q, D_A1) && (e_q.tnew == '0))      Fwd_D_rs = 2'd1;
    else if (wr_hit(m_q, D_A1) && (m_q.tnew == '0)) Fwd_D_rs = 2'd2;

    if (wr_hit(e_q, D_A2) && (e_q.tnew == '0))      Fwd_D_rt = 2'd1;
    else if (wr_hit(m_q, D_A2) && (m_q.tnew == '0)) Fwd_D_rt = 2'd2;

    if (wr_hit(m_q, e_q.a1) && (m_q.tnew == '0))    Fwd_E_rs = 2'd1;
    else if (wr_hit(w_q, e_q.a1))                   Fwd_E_rs = 2'd2;

    if (wr_hit(m_q, e_q.a2) && (m_q.tnew == '0))    Fwd_E_rt = 2'd1;
    else if (wr_hit(w_q, e_q.a2))                   Fwd_E_rt = 2'd2;

    Fwd_M_rt = wr_hit(w_q, m_q.a2);
  end

  // Source indices of W, W's Tnew and M's rs index are carried for slot uniformity but never consulted.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{w_q.a1, w_q.a2, w_q.tnew, m_q.a1};

`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] cnt_q;

  // Count stalled cycles; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset)      cnt_q <= '0;
    else if (stall) cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
